// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache controller: load/store width codes,
// controller state encoding and address-split helpers.
package dcache_pkg;

    // RISC-V funct3 width/sign codes used by loads and stores
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_MISS = 2'd1,
        WR_THRU = 2'd2
    } dcache_state_t;

    // Number of index bits needed to address num_sets sets (power of two)
    function automatic int idx_width(input int num_sets);
        return $clog2(num_sets);
    endfunction

endpackage

// File: rtl/dcache_if.sv
// CPU-side and memory-side bus of the data cache controller.
//
// Handshake rules:
//   CPU side    : cpu_valid and every cpu_* request field stay stable until the
//                 cycle cpu_ready is high; cpu_ready is a single-cycle
//                 completion pulse, and cpu_rdata/cpu_err are valid only in it.
//   Memory side : mem_req and every mem_* request field stay stable until the
//                 cycle mem_ack is high; mem_rdata is sampled in that cycle.
// The slave modport is the cache controller; the master modport is the
// environment (CPU pipeline plus backing memory). dbg_state mirrors the
// controller FSM state for observation.
interface dcache_if
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
);
    logic                  cpu_valid;
    logic                  cpu_we;
    logic [2:0]            cpu_funct3;
    logic [ADDR_WIDTH-1:0] cpu_addr;
    logic [31:0]           cpu_wdata;
    logic                  cpu_flush;
    logic                  cpu_ready;
    logic [31:0]           cpu_rdata;
    logic                  cpu_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [31:0]           mem_wdata;
    logic [3:0]            mem_wstrb;
    logic                  mem_ack;
    logic [31:0]           mem_rdata;

    dcache_state_t         dbg_state;

    modport slave (
        input  cpu_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, cpu_flush,
        output cpu_ready, cpu_rdata, cpu_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ack, mem_rdata,
        output dbg_state
    );

    modport master (
        output cpu_valid, cpu_we, cpu_funct3, cpu_addr, cpu_wdata, cpu_flush,
        input  cpu_ready, cpu_rdata, cpu_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb,
        output mem_ack, mem_rdata,
        input  dbg_state
    );

endinterface

// File: rtl/dcache_lsu_fmt.sv
// Load/store formatter: extracts and extends load data from a word, builds
// store strobes and lane-replicated store data, and flags illegal or
// misaligned accesses. Purely combinational so it can also sit on the
// uncached MMIO path.
module dcache_lsu_fmt
    import dcache_pkg::*;
(
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] rdata,
    output logic [31:0] wlanes,
    output logic [3:0]  wstrb,
    output logic        err
);

    logic [7:0]  sel_b;
    logic [15:0] sel_h;

    // Illegal width codes, unsigned stores and misaligned halves/words
    always_comb begin
        err = 1'b0;
        case (funct3)
            F3_B:    err = 1'b0;
            F3_H:    err = offset[0];
            F3_W:    err = |offset;
            F3_BU:   err = we;
            F3_HU:   err = we | offset[0];
            default: err = 1'b1;
        endcase
    end

    // Pick the addressed byte and half out of the word
    always_comb begin
        case (offset)
            2'd0:    sel_b = rword[7:0];
            2'd1:    sel_b = rword[15:8];
            2'd2:    sel_b = rword[23:16];
            default: sel_b = rword[31:24];
        endcase
        sel_h = offset[1] ? rword[31:16] : rword[15:0];
    end

    // Sign- or zero-extend the selected load data; errors return zero
    always_comb begin
        case (funct3)
            F3_B:    rdata = {{24{sel_b[7]}}, sel_b};
            F3_H:    rdata = {{16{sel_h[15]}}, sel_h};
            F3_W:    rdata = rword;
            F3_BU:   rdata = {24'd0, sel_b};
            F3_HU:   rdata = {16'd0, sel_h};
            default: rdata = 32'd0;
        endcase
        if (err) begin
            rdata = 32'd0;
        end
    end

    // Store strobes shifted to the byte offset and data replicated into lanes
    always_comb begin
        case (funct3)
            F3_B: begin
                wstrb  = 4'b0001 << offset;
                wlanes = {4{wdata[7:0]}};
            end
            F3_H: begin
                wstrb  = 4'b0011 << offset;
                wlanes = {2{wdata[15:0]}};
            end
            default: begin
                wstrb  = 4'b1111;
                wlanes = wdata;
            end
        endcase
        if (err) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/dcache_ctrl.sv
// Set-associative (1 or 2 way) write-through, no-write-allocate data cache
// controller with one 32-bit word per line and per-set LRU replacement.
// Load hits complete in the request cycle; misses and stores go to memory.
// Build option: define DCACHE_STATS_EN to keep the saturating hit/miss
// counters; otherwise both counter outputs are tied to zero.
module dcache_ctrl
    import dcache_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int NUM_SETS   = 16,
    parameter int WAYS       = 2,
    parameter int CNT_WIDTH  = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    dcache_if.slave              bus,
    output logic [CNT_WIDTH-1:0] hitcount,
    output logic [CNT_WIDTH-1:0] misscount
);

    localparam int IW = idx_width(NUM_SETS);
    localparam int TW = ADDR_WIDTH - 2 - IW;

    // Address split of the presented request
    logic [1:0]    off;
    logic [IW-1:0] idx;
    logic [TW-1:0] tag;

    assign off = bus.cpu_addr[1:0];
    assign idx = bus.cpu_addr[2 +: IW];
    assign tag = bus.cpu_addr[ADDR_WIDTH-1 -: TW];

    // Line storage; lru_q[set] names the way to evict next
    logic [NUM_SETS-1:0] valid_q [WAYS];
    logic [TW-1:0]       tag_q   [WAYS][NUM_SETS];
    logic [31:0]         data_q  [WAYS][NUM_SETS];
    logic [NUM_SETS-1:0] lru_q;

    dcache_state_t         state_q;
    logic                  flush_pend_q;
    logic                  st_hit_q;
    logic                  st_way_q;
    logic                  mem_req_q;
    logic                  mem_we_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [31:0]           mem_wdata_q;
    logic [3:0]            mem_wstrb_q;

    logic        hit;
    logic        hit_w;
    logic [31:0] hit_data;
    logic        all_valid;
    logic        victim;
    logic [31:0] fmt_rword;
    logic [31:0] fmt_rdata;
    logic [31:0] fmt_wlanes;
    logic [3:0]  fmt_wstrb;
    logic        fmt_err;

    logic flush_now, req_ok, err_ev, hit_ev, miss_ev, st_ev, fill_ev, wdone_ev;

    // Tag compare across all ways of the addressed set
    always_comb begin
        hit      = 1'b0;
        hit_w    = 1'b0;
        hit_data = 32'd0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[w][idx] && (tag_q[w][idx] == tag)) begin
                hit      = 1'b1;
                hit_w    = 1'(w);
                hit_data = data_q[w][idx];
            end
        end
    end

    // Victim: lowest-numbered invalid way, else the LRU way
    always_comb begin
        all_valid = 1'b1;
        victim    = 1'b0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!valid_q[w][idx]) begin
                all_valid = 1'b0;
                victim    = 1'(w);
            end
        end
        if (all_valid && (WAYS > 1)) begin
            victim = lru_q[idx];
        end
    end

    // Fill data comes straight from memory; hit data from the array
    assign fmt_rword = (state_q == RD_MISS) ? bus.mem_rdata : hit_data;

    dcache_lsu_fmt u_fmt (
        .we     (bus.cpu_we),
        .funct3 (bus.cpu_funct3),
        .offset (off),
        .wdata  (bus.cpu_wdata),
        .rword  (fmt_rword),
        .rdata  (fmt_rdata),
        .wlanes (fmt_wlanes),
        .wstrb  (fmt_wstrb),
        .err    (fmt_err)
    );

    // Event decode; a flush (new or pending) blocks acceptance in IDLE
    always_comb begin
        flush_now = (state_q == IDLE) && (bus.cpu_flush || flush_pend_q);
        req_ok    = (state_q == IDLE) && bus.cpu_valid && !flush_now;
        err_ev    = req_ok && fmt_err;
        hit_ev    = req_ok && !fmt_err && !bus.cpu_we && hit;
        miss_ev   = req_ok && !fmt_err && !bus.cpu_we && !hit;
        st_ev     = req_ok && !fmt_err && bus.cpu_we;
        fill_ev   = (state_q == RD_MISS) && bus.mem_ack;
        wdone_ev  = (state_q == WR_THRU) && bus.mem_ack;
    end

    assign bus.cpu_ready = err_ev | hit_ev | fill_ev | wdone_ev;
    assign bus.cpu_err   = err_ev;
    assign bus.cpu_rdata = (hit_ev | fill_ev) ? fmt_rdata : 32'd0;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_wstrb = mem_wstrb_q;
    assign bus.dbg_state = state_q;

    // Controller FSM with valid/LRU bookkeeping and registered memory request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            for (int w = 0; w < WAYS; w++) begin
                valid_q[w] <= '0;
            end
            lru_q        <= '0;
            flush_pend_q <= 1'b0;
            st_hit_q     <= 1'b0;
            st_way_q     <= 1'b0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= 32'd0;
            mem_wstrb_q  <= 4'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (flush_now) begin
                        for (int w = 0; w < WAYS; w++) begin
                            valid_q[w] <= '0;
                        end
                        flush_pend_q <= 1'b0;
                    end else if (hit_ev) begin
                        lru_q[idx] <= ~hit_w;
                    end else if (miss_ev) begin
                        state_q     <= RD_MISS;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b0;
                        mem_addr_q  <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= 32'd0;
                        mem_wstrb_q <= 4'd0;
                    end else if (st_ev) begin
                        state_q     <= WR_THRU;
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= {bus.cpu_addr[ADDR_WIDTH-1:2], 2'b00};
                        mem_wdata_q <= fmt_wlanes;
                        mem_wstrb_q <= fmt_wstrb;
                        st_hit_q    <= hit;
                        st_way_q    <= hit_w;
                    end
                end
                RD_MISS: begin
                    if (bus.cpu_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        for (int w = 0; w < WAYS; w++) begin
                            if (victim == 1'(w)) begin
                                valid_q[w][idx] <= 1'b1;
                            end
                        end
                        lru_q[idx] <= ~victim;
                        state_q    <= IDLE;
                        mem_req_q  <= 1'b0;
                        mem_we_q   <= 1'b0;
                    end
                end
                WR_THRU: begin
                    if (bus.cpu_flush) begin
                        flush_pend_q <= 1'b1;
                    end
                    if (bus.mem_ack) begin
                        if (st_hit_q) begin
                            lru_q[idx] <= ~st_way_q;
                        end
                        state_q   <= IDLE;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Tag/data writes on fill, and strobed merge on a write-through hit
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_ev && (victim == 1'(w))) begin
                tag_q[w][idx]  <= tag;
                data_q[w][idx] <= bus.mem_rdata;
            end
            if (wdone_ev && st_hit_q && (st_way_q == 1'(w))) begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_wstrb_q[b]) begin
                        data_q[w][idx][8*b +: 8] <= mem_wdata_q[8*b +: 8];
                    end
                end
            end
        end
    end

`ifdef DCACHE_STATS_EN
    logic [CNT_WIDTH-1:0] hit_cnt_q;
    logic [CNT_WIDTH-1:0] miss_cnt_q;

    // Saturating load hit/miss counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (hit_ev && (hit_cnt_q != '1)) begin
                hit_cnt_q <= hit_cnt_q + CNT_WIDTH'(1);
            end
            if (miss_ev && (miss_cnt_q != '1)) begin
                miss_cnt_q <= miss_cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    assign hitcount  = hit_cnt_q;
    assign misscount = miss_cnt_q;
`else
    assign hitcount  = '0;
    assign misscount = '0;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Testbench for dcache_ctrl: table of load/store vectors plus hand-written
// sequences for flush, reset-during-miss and stray acks.
module tb_dcache_ctrl;
  import dcache_pkg::*;

  localparam int K_HIT  = 0;
  localparam int K_MISS = 1;
  localparam int K_ST   = 2;
  localparam int K_ERR  = 3;

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          kind;
    logic [31:0] exp_rdata;
    logic [3:0]  exp_strb;
    logic [31:0] exp_mwdata;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst_n;
  logic [31:0] hitcount;
  logic [31:0] misscount;

  dcache_if #(.ADDR_WIDTH(32)) bus ();

  dcache_ctrl #(
    .ADDR_WIDTH(32),
    .NUM_SETS  (16),
    .WAYS      (2),
    .CNT_WIDTH (32)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .hitcount (hitcount),
    .misscount(misscount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int          checks   = 0;
  int          failures = 0;
  int          n_hit    = 0;
  int          n_miss   = 0;
  logic [32:0] exp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  vec_t        vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_exp(input int n);
`ifdef DCACHE_STATS_EN
    return 32'(n);
`else
    return (n == 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem_model.exists(a)) return mem_model[a];
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic vec_t mk(input logic we, input logic [2:0] f3, input logic [31:0] a,
                              input logic [31:0] wd, input int kind, input logic [31:0] rd,
                              input logic [3:0] st, input logic [31:0] mwd);
    vec_t v;
    v.we = we; v.f3 = f3; v.addr = a; v.wdata = wd; v.kind = kind;
    v.exp_rdata = rd; v.exp_strb = st; v.exp_mwdata = mwd;
    return v;
  endfunction

  // ---------------- driver ----------------
  // Entered at a negedge; presents the request, plays the memory side and
  // pops the scoreboard when cpu_ready pulses.
  task automatic do_req(input vec_t v, input string nm, input int ack_delay, input int flush_cyc,
                        output logic saw, output int lat, output logic mwe,
                        output logic [31:0] maddr, output logic [31:0] mwd, output logic [3:0] mst);
    logic        done;
    int          waited;
    int          rc;
    logic [32:0] e;
    logic [31:0] merged;
    done = 1'b0; waited = 0; rc = 0; saw = 1'b0; lat = -1;
    mwe = 1'b0; maddr = 32'd0; mwd = 32'd0; mst = 4'd0;
    bus.cpu_valid  = 1'b1;
    bus.cpu_we     = v.we;
    bus.cpu_funct3 = v.f3;
    bus.cpu_addr   = v.addr;
    bus.cpu_wdata  = v.wdata;
    while (!done && waited < 200) begin
      if (bus.mem_req) begin
        if (!saw) begin
          saw = 1'b1; mwe = bus.mem_we; maddr = bus.mem_addr;
          mwd = bus.mem_wdata; mst = bus.mem_wstrb;
        end
        if (rc == flush_cyc) bus.cpu_flush = 1'b1;
        if (rc == ack_delay) begin
          bus.mem_ack = 1'b1;
          if (bus.mem_we) begin
            merged = mem_rd(bus.mem_addr);
            for (int b = 0; b < 4; b++)
              if (bus.mem_wstrb[b]) merged[8*b +: 8] = bus.mem_wdata[8*b +: 8];
            mem_model[bus.mem_addr] = merged;
            bus.mem_rdata = 32'hFFFF_FFFF;
          end else begin
            bus.mem_rdata = mem_rd(bus.mem_addr);
          end
        end
        rc++;
      end
      #1;
      if (bus.cpu_ready) begin
        done = 1'b1;
        lat  = waited;
        if (exp_q.size() == 0) begin
          chk($sformatf("%s.unexpected_ready", nm), 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("%s.rdata", nm), bus.cpu_rdata, e[31:0]);
          chk($sformatf("%s.err", nm), 32'(bus.cpu_err), 32'(e[32]));
        end
      end
      @(negedge clk);
      bus.mem_ack   = 1'b0;
      bus.cpu_flush = 1'b0;
      waited++;
    end
    bus.cpu_valid = 1'b0;
    if (!done) begin
      chk($sformatf("%s.ready_timeout", nm), 32'd0, 32'd1);
      if (exp_q.size() != 0) void'(exp_q.pop_front());
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm, input int flush_cyc);
    logic        saw;
    int          lat;
    logic        mwe;
    logic [31:0] maddr;
    logic [31:0] mwd;
    logic [3:0]  mst;
    exp_q.push_back({(v.kind == K_ERR), v.exp_rdata});
    do_req(v, nm, 3, flush_cyc, saw, lat, mwe, maddr, mwd, mst);
    chk($sformatf("%s.mem_used", nm), 32'(saw), 32'((v.kind == K_MISS) || (v.kind == K_ST)));
    if (v.kind == K_HIT || v.kind == K_ERR) chk($sformatf("%s.latency", nm), 32'(lat), 32'd0);
    if (saw) begin
      chk($sformatf("%s.mem_we", nm), 32'(mwe), 32'(v.we));
      chk($sformatf("%s.mem_addr", nm), maddr, {v.addr[31:2], 2'b00});
      if (v.kind == K_ST) begin
        chk($sformatf("%s.mem_wstrb", nm), 32'(mst), 32'(v.exp_strb));
        chk($sformatf("%s.mem_wdata", nm), mwd, v.exp_mwdata);
      end
    end
    if (v.kind == K_HIT)  n_hit++;
    if (v.kind == K_MISS) n_miss++;
    chk($sformatf("%s.hitcount", nm), hitcount, cnt_exp(n_hit));
    chk($sformatf("%s.misscount", nm), misscount, cnt_exp(n_miss));
  endtask

  // ---------------- test ----------------
  initial begin
    rst_n = 1'b0;
    bus.cpu_valid = 1'b0; bus.cpu_we = 1'b0; bus.cpu_funct3 = 3'd0;
    bus.cpu_addr = 32'd0; bus.cpu_wdata = 32'd0; bus.cpu_flush = 1'b0;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'd0;

    mem_model[32'h100] = 32'hDEAD_BEEF;
    mem_model[32'h104] = 32'h1234_80FF;

    //             we    f3      addr        wdata         kind    rdata          strb     mem wdata
    vecs.push_back(mk(1'b0, F3_W,  32'h100, 32'h0,        K_MISS, 32'hDEAD_BEEF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h100, 32'h0,        K_HIT,  32'hDEAD_BEEF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_B,  32'h105, 32'h0,        K_MISS, 32'hFFFF_FF80, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_BU, 32'h105, 32'h0,        K_HIT,  32'h0000_0080, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_HU, 32'h106, 32'h0,        K_HIT,  32'h0000_1234, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_H,  32'h104, 32'h0,        K_HIT,  32'hFFFF_80FF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_B,  32'h104, 32'h0,        K_HIT,  32'hFFFF_FFFF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, F3_B,  32'h107, 32'h0000_00AA, K_ST,  32'h0,         4'h8, 32'hAAAA_AAAA));
    vecs.push_back(mk(1'b0, F3_W,  32'h104, 32'h0,        K_HIT,  32'hAA34_80FF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, F3_W,  32'h300, 32'h5566_7788, K_ST,  32'h0,         4'hF, 32'h5566_7788));
    vecs.push_back(mk(1'b0, F3_W,  32'h300, 32'h0,        K_MISS, 32'h5566_7788, 4'h0, 32'h0));
    vecs.push_back(mk(1'b1, F3_H,  32'h302, 32'h0000_BEEF, K_ST,  32'h0,         4'hC, 32'hBEEF_BEEF));
    vecs.push_back(mk(1'b0, F3_HU, 32'h302, 32'h0,        K_HIT,  32'h0000_BEEF, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h302, 32'h0,        K_ERR,  32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1'b1, F3_H,  32'h001, 32'h1234,     K_ERR,  32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1'b0, 3'b011, 32'h100, 32'h0,       K_ERR,  32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1'b1, F3_BU, 32'h100, 32'h0,        K_ERR,  32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_H,  32'h103, 32'h0,        K_ERR,  32'h0,         4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h008, 32'h0,        K_MISS, 32'hC0DE_0008, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h048, 32'h0,        K_MISS, 32'hC0DE_0048, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h008, 32'h0,        K_HIT,  32'hC0DE_0008, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h088, 32'h0,        K_MISS, 32'hC0DE_0088, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h008, 32'h0,        K_HIT,  32'hC0DE_0008, 4'h0, 32'h0));
    vecs.push_back(mk(1'b0, F3_W,  32'h048, 32'h0,        K_MISS, 32'hC0DE_0048, 4'h0, 32'h0));

    // Reset values
    repeat (2) @(negedge clk);
    #1;
    chk("rst.cpu_ready", 32'(bus.cpu_ready), 32'd0);
    chk("rst.cpu_err", 32'(bus.cpu_err), 32'd0);
    chk("rst.cpu_rdata", bus.cpu_rdata, 32'd0);
    chk("rst.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst.mem_we", 32'(bus.mem_we), 32'd0);
    chk("rst.mem_addr", bus.mem_addr, 32'd0);
    chk("rst.mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst.mem_wstrb", 32'(bus.mem_wstrb), 32'd0);
    chk("rst.hitcount", hitcount, 32'd0);
    chk("rst.misscount", misscount, 32'd0);
    chk("rst.state", 32'(bus.dbg_state), 32'(IDLE));
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table-driven vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i), -1);
    end

    // Flush together with a request that would hit: flush wins, no ready
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = F3_W;
    bus.cpu_addr = 32'h100; bus.cpu_flush = 1'b1;
    #1;
    chk("flush_idle.ready", 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    bus.cpu_flush = 1'b0;
    run_vec(mk(1'b0, F3_W, 32'h100, 32'h0, K_MISS, 32'hDEAD_BEEF, 4'h0, 32'h0), "flush_idle.reload", -1);

    // Flush during a read miss: filled line and everything else invalid afterwards
    run_vec(mk(1'b0, F3_W, 32'h00C, 32'h0, K_MISS, 32'hC0DE_000C, 4'h0, 32'h0), "flush_miss.fill", 1);
    run_vec(mk(1'b0, F3_W, 32'h00C, 32'h0, K_MISS, 32'hC0DE_000C, 4'h0, 32'h0), "flush_miss.refill", -1);
    run_vec(mk(1'b0, F3_W, 32'h100, 32'h0, K_MISS, 32'hDEAD_BEEF, 4'h0, 32'h0), "flush_miss.other", -1);

    // Stray ack while idle is ignored
    bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1111_2222;
    #1;
    chk("stray_ack.ready", 32'(bus.cpu_ready), 32'd0);
    @(negedge clk);
    bus.mem_ack = 1'b0;
    #1;
    chk("stray_ack.state", 32'(bus.dbg_state), 32'(IDLE));
    chk("stray_ack.mem_req", 32'(bus.mem_req), 32'd0);
    @(negedge clk);

    // Reset in the middle of a read miss
    bus.cpu_valid = 1'b1; bus.cpu_we = 1'b0; bus.cpu_funct3 = F3_W; bus.cpu_addr = 32'h200;
    repeat (2) @(negedge clk);
    chk("rst_miss.req_before", 32'(bus.mem_req), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rst_miss.mem_req", 32'(bus.mem_req), 32'd0);
    chk("rst_miss.state", 32'(bus.dbg_state), 32'(IDLE));
    chk("rst_miss.hitcount", hitcount, 32'd0);
    chk("rst_miss.misscount", misscount, 32'd0);
    bus.cpu_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    n_hit = 0; n_miss = 0;
    @(negedge clk);
    run_vec(mk(1'b0, F3_W, 32'h100, 32'h0, K_MISS, 32'hDEAD_BEEF, 4'h0, 32'h0), "post_rst.miss", -1);
    run_vec(mk(1'b0, F3_W, 32'h100, 32'h0, K_HIT, 32'hDEAD_BEEF, 4'h0, 32'h0), "post_rst.hit", -1);

    chk("scoreboard.empty", 32'(exp_q.size()), 32'd0);

    // Final report
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dcache_ctrl.md
Name: dcache_ctrl

Overview:
Parametrised set-associative data cache controller between the CPU memory stage and a word-wide backing data memory.
- Replaces the fixed direct-lookup scheme.
- Adds configurable sets and ways, and an LRU replacement policy.
- Adds a valid/ready CPU handshake with stall-on-miss, a request/ack memory port, and RISC-V byte/half/word load/store formatting.
- Policy: write-through, no-write-allocate. One 32-bit word per line. Saturating hit/miss counters.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- NUM_SETS, 16, number of sets; power of two, at least 2.
- WAYS, 2, associativity; legal values 1 or 2.
- CNT_WIDTH, 32, width of the hit/miss counters.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cpu_valid  in  1  request valid; held stable with all request fields until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_funct3  in  3  RISC-V width/sign code (000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU).
- cpu_addr  in  ADDR_WIDTH  byte address.
- cpu_wdata  in  32  store data, right-aligned.
- cpu_flush  in  1  invalidate all lines.
- cpu_ready  out  1  one-cycle completion pulse.
- cpu_rdata  out  32  formatted load data; valid while cpu_ready is high.
- cpu_err  out  1  misaligned or illegal access; valid with cpu_ready.
- mem_req  out  1  memory request; held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0).
- mem_wdata  out  32  lane-aligned write data.
- mem_wstrb  out  4  byte strobes.
- mem_ack  in  1  memory completion; mem_rdata valid on a read ack.
- mem_rdata  in  32  memory read word.
- hitcount  out  CNT_WIDTH  load hits.
- misscount  out  CNT_WIDTH  load misses.

Behaviour:
- Address split:
  - offset = addr[1:0].
  - index = addr[2 +: log2(NUM_SETS)].
  - tag = the remaining upper bits.
- Storage is flop arrays: valid, tag and data per way per set, plus one LRU bit per set (the LRU bit is unused when WAYS = 1).
- Reset: all valid and LRU bits cleared; state IDLE; cpu_ready, cpu_err, mem_req, mem_we at 0; mem_addr, mem_wdata, mem_wstrb, cpu_rdata at 0; counters at 0.
- FSM states: IDLE, RD_MISS, WR_THRU.
- IDLE: lookup is combinational on cpu_addr whenever cpu_valid is high.
  - Error check, which takes precedence over everything below. Any of these gives cpu_ready = 1 and cpu_err = 1 in the same cycle, with rdata 0, no memory access and no counter change:
    - funct3 011, 110 or 111;
    - store with funct3 100 or 101;
    - half access with addr[0] = 1;
    - word access with addr[1:0] ≠ 0.
  - Load hit: cpu_ready = 1 in the same cycle (zero wait), the LRU bit points at the other way, and hitcount increments.
  - Load miss: go to RD_MISS, misscount increments.
  - Store (hit or miss): go to WR_THRU.
- RD_MISS:
  - mem_req = 1, mem_we = 0, mem_addr = the word address.
  - On mem_ack: fill the victim way (an invalid way first, preferring way 0, otherwise the LRU way). Write tag and data, set valid, update LRU, and pulse cpu_ready with rdata formatted from mem_rdata in the same cycle. Return to IDLE.
- WR_THRU:
  - mem_req = 1, mem_we = 1; wstrb is 0001, 0011 or 1111 shifted by the offset; wdata is replicated into lanes.
  - On mem_ack: if the address hit at acceptance, merge the strobed bytes into the cached word and update LRU; a store miss does not allocate. Pulse cpu_ready and return to IDLE.
- Load formatting: select the byte or half by offset. LB/LH sign-extend, LBU/LHU zero-extend.
- Flush:
  - In IDLE, cpu_flush clears all valid bits in one cycle. It has priority over a simultaneous cpu_valid, so cpu_ready stays 0 that cycle and the request is serviced next cycle.
  - In RD_MISS or WR_THRU, a flush is held pending and applied on the cycle after the ack. The line just filled is therefore also invalidated.
- Counters saturate at all-ones and never wrap.
- Reset during RD_MISS or WR_THRU: the transaction is abandoned and mem_req drops asynchronously. The memory side must discard the request.
- mem_ack outside RD_MISS/WR_THRU is ignored.

Optional Feature:
- Macro DCACHE_STATS_EN.
- Defined: hitcount and misscount behave as above.
- Undefined: counter logic is removed and both outputs are tied to 0. Ports are unchanged.

Decomposition:
- Shared package dcache_pkg holds:
  - the funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - the state enum typedef dcache_state_t;
  - a function computing the index width from NUM_SETS.
- One natural sub-module, dcache_lsu_fmt: combinational load extraction/extension plus store strobe/lane generation and misalignment detection. It is shared with the uncached MMIO path.

Test Plan:
1. After reset, LW 0x100 → miss, mem_req asserted; ack with 0xDEADBEEF after 3 cycles → cpu_rdata 0xDEADBEEF, misscount 1. Repeat LW 0x100 → ready in the same cycle, hitcount 1.
2. LB 0x101 with the line holding 0x1234_80FF → cpu_rdata 0xFFFFFF80. LBU 0x101 → 0x00000080. LHU 0x102 → 0x00001234.
3. SB 0x103 data 0xAA on a hit → mem_wstrb 1000, mem_wdata 0xAAAAAAAA. After ack, LW 0x100 hits and returns 0xAA34_80FF. SW to an uncached address → no allocation; a following LW to it misses.
4. WAYS = 2, NUM_SETS = 16: fill 0x000 and 0x040 (same set), read 0x000, then load 0x080 → 0x040 is evicted. Re-read 0x000 hits, 0x040 misses.
5. LW 0x102, SH 0x001 and funct3 011 → cpu_err = 1 with ready in the same cycle, mem_req never asserted, counters unchanged.
6. Flush while in RD_MISS → the line is invalid after the ack and the next load misses. Reset asserted mid-RD_MISS → mem_req low immediately and counters 0.
